aer_encoder: RTL
================

AER_ENCODER -- requirements
Module: aer_encoder

Interface
REQ-001 Parameter N_CH, default 16: number of spike channels; channel index width is 4.
REQ-002 Parameter FIFO_DEPTH, default 8: event FIFO depth in words, power of two.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 spike_in  input  N_CH  per-channel spike; each bit sampled high on an edge = one event.
REQ-006 aer_ready  input  1  downstream accepts the current word (tied 1 by a sink without backpressure).
REQ-007 aer_out  output  24  event word {channel[3:0], timestamp[19:0]}.
REQ-008 aer_valid  output  1  aer_out holds a valid event.
REQ-009 overflow  output  1  sticky; set on any dropped event.
REQ-010 drop_count  output  8  saturating count of dropped events.

Function
REQ-011 A 20-bit free-running timestamp counter SHALL increment every clock and wrap 0xFFFFF -> 0x00000.
REQ-012 On an edge where spike_in[i]=1 and channel i is not pending, pending[i] SHALL set and stamp[i] SHALL capture the current counter value.
REQ-013 On an edge where spike_in[i]=1 and channel i is pending and not granted that cycle, the new event SHALL be dropped, the held event kept, drop_count incremented (saturating at 0xFF) and overflow set.
REQ-014 If channel i is granted and spike_in[i]=1 on the same edge, the grant SHALL complete and the new event SHALL become pending with the current stamp; no drop.
REQ-015 Arbiter: each cycle with any pending channel and FIFO not full, exactly one channel SHALL be granted, searching round-robin from last_grant+1 (mod N_CH).
REQ-016 A grant SHALL clear pending[i], write {i, stamp[i]} to the FIFO and update last_grant to i.
REQ-017 When the FIFO is full no grant SHALL occur, even if a pop happens on the same edge; pending events wait and are not dropped.
REQ-018 Output stage: aer_out/aer_valid are registered; a transfer occurs on an edge with aer_valid=1 and aer_ready=1.
REQ-019 When aer_valid=0 or a transfer occurs, the output register SHALL load the FIFO head if non-empty (aer_valid=1), otherwise aer_valid SHALL go 0.
REQ-020 While aer_valid=1 and aer_ready=0, aer_out and aer_valid SHALL hold stable.
REQ-021 Latency on an idle encoder with aer_ready=1: aer_valid SHALL assert after the third rising edge following, and including, the edge that samples the spike (sample, grant/write, output load).
REQ-022 Event order at the output SHALL equal grant order; no event is duplicated or reordered.
REQ-023 Sustained throughput SHALL be one event per clock while aer_ready=1.

Reset
REQ-024 Asserting rst_n SHALL immediately clear: counter=0, pending=0, stamps=0, last_grant=N_CH-1, FIFO empty, aer_out=0, aer_valid=0, overflow=0, drop_count=0.
REQ-025 Reset mid-operation SHALL discard all pending and buffered events; none appear after release.
REQ-026 The first edge after release SHALL behave as a normal operating edge.

Structure
REQ-027 Shared package aer_pkg SHALL define CH_W=4, TS_W=20, AER_W=24 and the word field positions, shared with the AER input decoder.
REQ-028 The FIFO SHALL be a separate sub-module aer_sync_fifo (synchronous, full/empty flags, registered pointers with one extra wrap bit).
REQ-029 Arbiter, pending/stamp registers, counter and output stage SHALL reside in aer_encoder.

Verification
REQ-030 Reset, spike_in[5] pulsed when counter=0x00010, aer_ready=1 -> single word aer_out=0x500010, aer_valid high for exactly one cycle, at REQ-021 latency.
REQ-031 spike_in bits 0, 3 and 15 pulsed together at counter=T after reset -> three consecutive words with channels 0, 3, 15, all timestamps T.
REQ-032 Spike on channel 7 at counter 0xFFFFF and again one clock later with aer_ready=1 -> timestamps 0xFFFFF then 0x00000.
REQ-033 aer_ready=0; pulse channels 0..9 once each on consecutive cycles -> 9 words buffered (1 output + 8 FIFO), channel 9 stays pending; raise aer_ready -> 10 words in order 0..9, aer_out stable while stalled.
REQ-034 With FIFO full and channel 2 pending, pulse channel 2 three more times -> drop_count=3, overflow=1, exactly one channel-2 word with the original stamp.
REQ-035 Assert rst_n low for one cycle while the FIFO holds 4 words -> aer_valid=0 immediately, no words emitted after release, all counters 0.

Source files
------------

// File: rtl/aer_pkg.sv
// Shared AER word format: channel/timestamp widths and field positions,
// used by both the encoder and the AER input decoder.
package aer_pkg;

    localparam int CH_W  = 4;
    localparam int TS_W  = 20;
    localparam int AER_W = 24;

    localparam int TS_LSB = 0;
    localparam int TS_MSB = TS_W - 1;
    localparam int CH_LSB = TS_W;
    localparam int CH_MSB = AER_W - 1;

    typedef logic [CH_W-1:0]  ch_t;
    typedef logic [TS_W-1:0]  ts_t;
    typedef logic [AER_W-1:0] aer_word_t;

    function automatic aer_word_t aer_pack(input ch_t ch, input ts_t ts);
        aer_word_t w;
        w = '0;
        w[CH_MSB:CH_LSB] = ch;
        w[TS_MSB:TS_LSB] = ts;
        return w;
    endfunction

endpackage

// File: rtl/aer_encoder_if.sv
// AER output handshake: registered word + valid from the encoder, ready from the sink.
interface aer_encoder_if import aer_pkg::*; ();

    aer_word_t aer_out;
    logic      aer_valid;
    logic      aer_ready;

    modport master (output aer_out, output aer_valid, input aer_ready);
    modport slave  (input aer_out, input aer_valid, output aer_ready);

endinterface

// File: rtl/aer_sync_fifo.sv
// Synchronous event FIFO; pointers carry one extra wrap bit to tell full from empty.
module aer_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // NOTE: storage is not reset; only the pointers decide which entries are live.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/aer_encoder.sv
// Spike-to-AER encoder: per-channel pending/stamp registers, round-robin arbiter,
// event FIFO and a registered valid/ready output stage.
module aer_encoder import aer_pkg::*; #(
    parameter int N_CH       = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   spike_in,
    aer_encoder_if.master     aer,
    output logic              overflow,
    output logic [7:0]        drop_count
);

    localparam int   CNT_W    = CH_W + 1;
    localparam ch_t  LAST_CH  = ch_t'(N_CH - 1);

    ts_t             ts_cnt;
    logic [N_CH-1:0] pending;
    ts_t             stamp [N_CH];
    ch_t             last_grant;

    logic            grant_valid;
    ch_t             grant_idx;
    logic [N_CH-1:0] grant_vec;
    logic [N_CH-1:0] drop_vec;
    logic [N_CH-1:0] capture_vec;
    logic [CNT_W-1:0] drop_n;
    logic [8:0]      drop_sum;

    logic            fifo_full;
    logic            fifo_empty;
    aer_word_t       fifo_dout;
    logic            out_load;

    // Round-robin search starting just after the last granted channel.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin : arbiter
        ch_t idx;
        grant_valid = 1'b0;
        grant_idx   = last_grant;
        idx         = last_grant;
        for (int off = 1; off <= N_CH; off++) begin
            idx = ch_t'((int'(last_grant) + off) % N_CH);
            if (!grant_valid && !fifo_full && pending[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    always_comb begin
        grant_vec = '0;
        if (grant_valid) grant_vec[grant_idx] = 1'b1;
        drop_vec    = spike_in & pending & ~grant_vec;
        capture_vec = spike_in & (~pending | grant_vec);
        drop_n      = CNT_W'($countones(drop_vec));
        drop_sum    = {1'b0, drop_count} + 9'(drop_n);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt     <= '0;
            pending    <= '0;
            last_grant <= LAST_CH;
            overflow   <= 1'b0;
            drop_count <= '0;
            for (int i = 0; i < N_CH; i++) stamp[i] <= '0;
        end else begin
            ts_cnt  <= ts_cnt + 1'b1;
            pending <= (pending & ~grant_vec) | spike_in;
            for (int i = 0; i < N_CH; i++) begin
                if (capture_vec[i]) stamp[i] <= ts_cnt;
            end
            if (grant_valid) last_grant <= grant_idx;
            if (|drop_vec) begin
                overflow   <= 1'b1;
                drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            end
        end
    end

    aer_sync_fifo #(
        .WIDTH (AER_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (grant_valid),
        .din   (aer_pack(grant_idx, stamp[grant_idx])),
        .pop   (out_load && !fifo_empty),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Output register refills whenever it is empty or its word is being taken.
    assign out_load = !aer.aer_valid || aer.aer_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aer.aer_out   <= '0;
            aer.aer_valid <= 1'b0;
        end else if (out_load) begin
            aer.aer_valid <= !fifo_empty;
            if (!fifo_empty) aer.aer_out <= fifo_dout;
        end
    end

endmodule
